// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one physical-memory line port between the I-cache and D-cache.
// Optional build macro ARB_ROUND_ROBIN_EN swaps fixed D priority for alternating priority.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]   pmem_wdata_q, pmem_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;
  logic                d_req;
  logic                grant_d;
  logic                grant_i;
`ifdef ARB_ROUND_ROBIN_EN
  // 0 = I was granted last, 1 = D was granted last.
  logic                last_grant_q, last_grant_d;
`endif

  always_comb begin
    d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d = d_req & (~i_read | ~last_grant_q);
`else
    grant_d = d_req;
`endif
    grant_i = i_read & ~grant_d;

    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    i_resp_d       = 1'b0;
    d_resp_d       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d   = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          pmem_address_d = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          pmem_write_d   = d_write;
          pmem_read_d    = d_read & ~d_write;
          pmem_wdata_d   = d_wdata;
          state_d        = BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d   = 1'b1;
`endif
        end else if (grant_i) begin
          pmem_address_d = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
          state_d        = BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d   = 1'b0;
`endif
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          i_rdata_d    = pmem_rdata;
          i_resp_d     = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = DONE_I;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          // A writeback returns no line, so d_rdata keeps its last read value.
          if (pmem_read_q) d_rdata_d = pmem_rdata;
          d_resp_d     = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = DONE_D;
        end
      end
      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      i_resp_q       <= i_resp_d;
      d_resp_q       <= d_resp_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;

endmodule
